// File: rtl/frame_uart_tx_pkg.sv
// ============================================================================
// Module   : frame_uart_tx_pkg
// Brief    : Shared constants for the frame dump UART: FSM encodings, UART
//            frame levels and the default host address width.
//            Optional macro: FRAME_DUMP_CHECKSUM_EN (adds the CSUM state).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_uart_tx_pkg;

  localparam int HADDR_WIDTH_DEF = 24;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_SEND_L = 3'd2;
  localparam logic [2:0] ST_SEND_H = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;
`ifdef FRAME_DUMP_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd6;
`endif

  localparam logic [1:0] UTX_IDLE  = 2'd0;
  localparam logic [1:0] UTX_START = 2'd1;
  localparam logic [1:0] UTX_DATA  = 2'd2;
  localparam logic [1:0] UTX_STOP  = 2'd3;

  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_uart_tx_uart.sv
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 byte serializer; a new byte offered in the last stop-bit
//            cycle starts the next frame with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import frame_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 218
) (
  input  logic       i_Clock,
  input  logic       rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    C_DATA_LAST = 3'(UART_DATA_BITS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          w_bit_end;

  assign w_bit_end = (cnt_q == C_BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    if (state_q != UTX_IDLE) begin
      cnt_d = w_bit_end ? '0 : cnt_q + CW'(1);
    end
    case (state_q)
      UTX_IDLE: begin
        cnt_d = '0;
        if (i_Tx_DV) begin
          data_d  = i_Tx_Byte;
          tx_d    = UART_START_BIT;
          state_d = UTX_START;
        end
      end
      UTX_START: begin
        if (w_bit_end) begin
          bit_d   = '0;
          tx_d    = data_q[0];
          state_d = UTX_DATA;
        end
      end
      UTX_DATA: begin
        if (w_bit_end) begin
          if (bit_q == C_DATA_LAST) begin
            tx_d    = UART_STOP_BIT;
            state_d = UTX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
      UTX_STOP: begin
        if (w_bit_end) begin
          // Back-to-back byte: start bit follows the stop bit directly
          if (i_Tx_DV) begin
            data_d  = i_Tx_Byte;
            tx_d    = UART_START_BIT;
            state_d = UTX_START;
          end else begin
            tx_d    = UART_STOP_BIT;
            state_d = UTX_IDLE;
          end
        end
      end
      default: begin
        tx_d    = UART_STOP_BIT;
        state_d = UTX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge rst) begin
    if (rst) begin
      state_q <= UTX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= UART_STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign o_Tx_Serial = tx_q;
  assign o_Tx_Active = (state_q != UTX_IDLE);
  assign o_Tx_Done   = (state_q == UTX_STOP) && w_bit_end;

endmodule

`default_nettype wire

// File: rtl/frame_uart_tx.sv
// ============================================================================
// Module   : frame_uart_tx
// Brief    : Dumps SDRAM words 0..LAST_ADDR over UART, low byte first.
//            Optional macro: FRAME_DUMP_CHECKSUM_EN appends a 16-bit sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_uart_tx
  import frame_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 218,
  parameter int LAST_ADDR    = 19220,
  parameter int HADDR_WIDTH  = HADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic                   rd_ready,
  input  logic [15:0]            rd_data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  logic [2:0]             state_q, state_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]            word_q, word_d;
`ifdef FRAME_DUMP_CHECKSUM_EN
  logic [15:0]            csum_q, csum_d;
  logic                   csum_hi_q, csum_hi_d;
`endif

  logic       w_tx_dv;
  logic [7:0] w_tx_byte;
  logic       w_tx_active;
  logic       w_tx_done;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    w_tx_dv   = 1'b0;
    w_tx_byte = word_q[7:0];
`ifdef FRAME_DUMP_CHECKSUM_EN
    csum_d    = csum_q;
    csum_hi_d = csum_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = ST_READ;
`ifdef FRAME_DUMP_CHECKSUM_EN
          csum_d    = '0;
          csum_hi_d = 1'b0;
`endif
        end
      end
      ST_READ: begin
        if (rd_ready) begin
          word_d  = rd_data;
          state_d = ST_SEND_L;
`ifdef FRAME_DUMP_CHECKSUM_EN
          csum_d = csum_add(csum_q, rd_data);
`endif
        end
      end
      ST_SEND_L: begin
        // Serializer is idle only on entry; its done strobe hands over the high byte
        if (!w_tx_active) begin
          w_tx_dv = 1'b1;
        end else if (w_tx_done) begin
          w_tx_dv   = 1'b1;
          w_tx_byte = word_q[15:8];
          state_d   = ST_SEND_H;
        end
      end
      ST_SEND_H: begin
        if (w_tx_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (addr_q == HADDR_WIDTH'(LAST_ADDR)) begin
`ifdef FRAME_DUMP_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_FIN;
`endif
        end else begin
          addr_d  = addr_q + HADDR_WIDTH'(1);
          state_d = ST_READ;
        end
      end
`ifdef FRAME_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        w_tx_byte = csum_q[7:0];
        if (!w_tx_active) begin
          w_tx_dv = 1'b1;
        end else if (w_tx_done) begin
          if (!csum_hi_q) begin
            w_tx_dv   = 1'b1;
            w_tx_byte = csum_q[15:8];
            csum_hi_d = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
`ifdef FRAME_DUMP_CHECKSUM_EN
      csum_q    <= '0;
      csum_hi_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
`ifdef FRAME_DUMP_CHECKSUM_EN
      csum_q    <= csum_d;
      csum_hi_q <= csum_hi_d;
`endif
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .i_Clock     (clk),
    .rst         (rst),
    .i_Tx_DV     (w_tx_dv),
    .i_Tx_Byte   (w_tx_byte),
    .o_Tx_Serial (tx),
    .o_Tx_Active (w_tx_active),
    .o_Tx_Done   (w_tx_done)
  );

  assign rd_addr   = addr_q;
  assign rd_enable = (state_q == ST_READ);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);

endmodule

`default_nettype wire
